// File: rtl/cpu_pkg.sv
// Shared constants for the execute/memory boundary:
// condition codes, flag bit positions and datapath width.
package cpu_pkg;

    localparam int DATA_W = 48;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_LT = 4'b0010;
    localparam logic [3:0] COND_GE = 4'b0011;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluation against the current
// architectural flags; unsupported codes never pass.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] FlagsQ,
    output logic       CondPass
);

    always_comb begin
        CondPass = 1'b0;
        unique case (CondE)
            COND_EQ: CondPass = FlagsQ[FLAG_Z];
            COND_NE: CondPass = !FlagsQ[FLAG_Z];
            COND_LT: CondPass = FlagsQ[FLAG_N];
            COND_GE: CondPass = !FlagsQ[FLAG_N];
            COND_AL: CondPass = 1'b1;
            default: CondPass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with predication, architectural
// flag register and retired-instruction counter.
module exmem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallM,
    input  logic              FlushM,
    input  logic              ValidE,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [3:0]        ALUFlags,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [RA_W-1:0]   WA3E,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemtoRegE,
    input  logic              FlagWriteE,
    input  logic [3:0]        CondE,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [RA_W-1:0]   WA3M,
    output logic              ValidM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              MemtoRegM,
    output logic              FwdEnM,
    output logic [3:0]        FlagsQ,
    output logic [15:0]       RetireCnt
);

    logic w_cond_pass;
    logic w_adv;
    logic w_exec;

    cond_check u_cond (
        .CondE    (CondE),
        .FlagsQ   (FlagsQ),
        .CondPass (w_cond_pass)
    );

    assign w_adv  = rst_n & !FlushM & !StallM;
    assign w_exec = w_adv & ValidE & w_cond_pass;
    assign FwdEnM = ValidM & RegWriteM;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
        end else if (FlushM) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
        end else if (w_adv) begin
            // Data moves even for squashed slots; controls carry the kill.
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
            ValidM     <= ValidE & w_cond_pass;
            RegWriteM  <= RegWriteE & ValidE & w_cond_pass;
            MemWriteM  <= MemWriteE & ValidE & w_cond_pass;
            MemtoRegM  <= MemtoRegE & ValidE & w_cond_pass;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            FlagsQ    <= 4'b0000;
            RetireCnt <= 16'h0000;
        end else if (w_exec) begin
            if (FlagWriteE) begin
                FlagsQ <= ALUFlags;
            end
            RetireCnt <= RetireCnt + 16'd1;
        end
    end

endmodule
